// File: rtl/pwm_duty_ctrl_pkg.sv
// Shared definitions for the duty controller and the downstream PWM stage.
package pwm_duty_ctrl_pkg;

   // Default duty range shared with the PWM stage
   localparam int DUTY_W_DEF    = 4;
   localparam int DUTY_MAX_DEF  = 10;
   localparam int DUTY_INIT_DEF = 5;

   // Debouncer states
   typedef enum logic [1:0] {
      ST_IDLE            = 2'd0,
      ST_CONFIRM_PRESS   = 2'd1,
      ST_PRESSED         = 2'd2,
      ST_CONFIRM_RELEASE = 2'd3
   } db_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm_duty_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, debounce FSM and auto-repeat timer.
// Emits a one-cycle step on a confirmed press, then after HOLD_CYCLES and
// every REPEAT_CYCLES thereafter while the button stays pressed.
module btn_debounce
   import pwm_duty_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 64,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_step
);

   localparam int DCNT_W = cnt_w(DEBOUNCE_CYCLES);
   localparam int RCNT_W = cnt_w((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCNT_W-1:0] HOLD_LAST = RCNT_W'(HOLD_CYCLES - 1);
   localparam logic [RCNT_W-1:0] REP_LAST  = RCNT_W'(REPEAT_CYCLES - 1);

   logic [1:0]        r_sync;
   db_state_t         r_state, w_state_nxt;
   logic [DCNT_W-1:0] r_dcnt, w_dcnt_nxt;
   logic [RCNT_W-1:0] r_rcnt, w_rcnt_nxt;
   logic              r_rep, w_rep_nxt;
   logic              r_step, w_step_nxt;
   logic              w_lvl;

   assign w_lvl  = r_sync[1];
   assign o_step = r_step;

   // Synchronise the raw asynchronous button into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= 2'b00;
      else        r_sync <= {r_sync[0], i_btn};
   end

   // State, counters and registered step pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_dcnt  <= '0;
         r_rcnt  <= '0;
         r_rep   <= 1'b0;
         r_step  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dcnt  <= w_dcnt_nxt;
         r_rcnt  <= w_rcnt_nxt;
         r_rep   <= w_rep_nxt;
         r_step  <= w_step_nxt;
      end
   end

   // Next-state, counter and step decode
   always_comb begin
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
      w_rcnt_nxt  = r_rcnt;
      w_rep_nxt   = r_rep;
      w_step_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_dcnt_nxt = '0;
            w_rcnt_nxt = '0;
            w_rep_nxt  = 1'b0;
            if (w_lvl) w_state_nxt = ST_CONFIRM_PRESS;
         end
         ST_CONFIRM_PRESS: begin
            if (!w_lvl) begin
               w_state_nxt = ST_IDLE;
               w_dcnt_nxt  = '0;
            end else if (r_dcnt == DCNT_LAST) begin
               // Confirmed press: first step, hold timer starts now
               w_state_nxt = ST_PRESSED;
               w_dcnt_nxt  = '0;
               w_rcnt_nxt  = '0;
               w_rep_nxt   = 1'b0;
               w_step_nxt  = 1'b1;
            end else begin
               w_dcnt_nxt = r_dcnt + 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!w_lvl) begin
               w_state_nxt = ST_CONFIRM_RELEASE;
               w_dcnt_nxt  = '0;
            end else if ((!r_rep && r_rcnt == HOLD_LAST) || (r_rep && r_rcnt == REP_LAST)) begin
               w_step_nxt = 1'b1;
               w_rcnt_nxt = '0;
               w_rep_nxt  = 1'b1;
            end else begin
               w_rcnt_nxt = r_rcnt + 1'b1;
            end
         end
         ST_CONFIRM_RELEASE: begin
            // A bounce back high resumes the press without a new step;
            // the repeat timer is held meanwhile
            if (w_lvl) begin
               w_state_nxt = ST_PRESSED;
               w_dcnt_nxt  = '0;
            end else if (r_dcnt == DCNT_LAST) begin
               w_state_nxt = ST_IDLE;
               w_dcnt_nxt  = '0;
            end else begin
               w_dcnt_nxt = r_dcnt + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle register driven by debounced inc/dec buttons with auto-repeat.
// Duty saturates at 0 and DUTY_MAX; simultaneous inc+dec steps cancel.
module pwm_duty_ctrl
   import pwm_duty_ctrl_pkg::*;
#(
   parameter int DUTY_W          = DUTY_W_DEF,
   parameter int DUTY_MAX        = DUTY_MAX_DEF,
   parameter int DUTY_INIT       = DUTY_INIT_DEF,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 64,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              btn_inc,
   input  logic              btn_dec,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_upd,
   output logic              at_max,
   output logic              at_min
);

   localparam logic [DUTY_W-1:0] D_MAX  = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] D_INIT = DUTY_W'(DUTY_INIT);

   logic              w_inc, w_dec;
   logic [DUTY_W-1:0] r_duty, w_duty_nxt;
   logic              r_upd, w_chg;
   logic              r_at_max, r_at_min;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
   ) u_db_inc (
      .clk   (clk),
      .rst_n (rst_n),
      .i_btn (btn_inc),
      .o_step(w_inc)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
   ) u_db_dec (
      .clk   (clk),
      .rst_n (rst_n),
      .i_btn (btn_dec),
      .o_step(w_dec)
   );

   // Saturating step; a blocked or cancelled step is not a change
   always_comb begin
      w_duty_nxt = r_duty;
      w_chg      = 1'b0;
      if (w_inc && !w_dec && r_duty != D_MAX) begin
         w_duty_nxt = r_duty + 1'b1;
         w_chg      = 1'b1;
      end else if (w_dec && !w_inc && r_duty != '0) begin
         w_duty_nxt = r_duty - 1'b1;
         w_chg      = 1'b1;
      end
   end

   // Duty and its flags update together on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_duty   <= D_INIT;
         r_upd    <= 1'b0;
         r_at_max <= (D_INIT == D_MAX);
         r_at_min <= (D_INIT == '0);
      end else begin
         r_duty   <= w_duty_nxt;
         r_upd    <= w_chg;
         r_at_max <= (w_duty_nxt == D_MAX);
         r_at_min <= (w_duty_nxt == '0);
      end
   end

   assign duty     = r_duty;
   assign duty_upd = r_upd;
   assign at_max   = r_at_max;
   assign at_min   = r_at_min;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl at default parameters.
module tb_pwm_duty_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_inc, btn_dec;
   logic [3:0] duty;
   logic       duty_upd, at_max, at_min;

   int npass = 0;
   int nchk  = 0;
   int ecnt  = 0;
   int upd_cnt = 0;
   int upd_q[$];

   pwm_duty_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_inc (btn_inc),
      .btn_dec (btn_dec),
      .duty    (duty),
      .duty_upd(duty_upd),
      .at_max  (at_max),
      .at_min  (at_min)
   );

   always #5 clk = ~clk;

   // Advance n edges, sampling 1 time unit after each rising edge
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         ecnt++;
         if (duty_upd === 1'b1) begin
            upd_cnt++;
            upd_q.push_back(ecnt);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic clr();
      ecnt = 0;
      upd_cnt = 0;
      upd_q.delete();
   endtask

   task automatic do_reset();
      btn_inc = 1'b0;
      btn_dec = 1'b0;
      rst_n = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(2);
   endtask

   task automatic press_dec();
      btn_dec = 1'b1;
      cyc(25);
      btn_dec = 1'b0;
      cyc(25);
   endtask

   initial begin
      rst_n = 1'b0;
      btn_inc = 1'b0;
      btn_dec = 1'b0;
      cyc(3);
      chk("rst_duty", duty, 5);
      chk("rst_upd", duty_upd, 0);
      chk("rst_at_max", at_max, 0);
      chk("rst_at_min", at_min, 0);
      rst_n = 1'b1;
      cyc(2);

      // Clean press held 40 cycles: single step, duty changes on edge 20
      clr();
      btn_inc = 1'b1;
      cyc(19);
      chk("s1_duty_e19", duty, 5);
      cyc(1);
      chk("s1_duty_e20", duty, 6);
      chk("s1_upd_e20", duty_upd, 1);
      cyc(20);
      chk("s1_upd_cnt", upd_cnt, 1);
      btn_inc = 1'b0;
      cyc(30);

      // Bouncing press never settles long enough
      do_reset();
      clr();
      for (int i = 0; i < 5; i++) begin
         btn_inc = 1'b1;
         cyc(3);
         btn_inc = 1'b0;
         cyc(3);
      end
      cyc(30);
      chk("s2_duty", duty, 5);
      chk("s2_upd_cnt", upd_cnt, 0);

      // Long hold: first step, hold delay, repeats, saturation at 10
      do_reset();
      clr();
      btn_inc = 1'b1;
      cyc(200);
      chk("s3_upd_cnt", upd_cnt, 5);
      if (upd_q.size() == 5) begin
         chk("s3_upd0", upd_q[0], 20);
         chk("s3_upd1", upd_q[1], 84);
         chk("s3_upd2", upd_q[2], 100);
         chk("s3_upd3", upd_q[3], 116);
         chk("s3_upd4", upd_q[4], 132);
      end
      chk("s3_duty", duty, 10);
      chk("s3_at_max", at_max, 1);
      chk("s3_at_min", at_min, 0);
      btn_inc = 1'b0;
      cyc(30);

      // Both buttons together cancel every step
      do_reset();
      clr();
      btn_inc = 1'b1;
      btn_dec = 1'b1;
      cyc(30);
      chk("s4_duty", duty, 5);
      chk("s4_upd_cnt", upd_cnt, 0);
      btn_inc = 1'b0;
      btn_dec = 1'b0;
      cyc(30);

      // Walk down to 1, then two dec presses: one change, then blocked at 0
      do_reset();
      for (int i = 0; i < 4; i++) press_dec();
      chk("s5_duty_1", duty, 1);
      chk("s5_at_min_0", at_min, 0);
      clr();
      press_dec();
      press_dec();
      chk("s5_duty_0", duty, 0);
      chk("s5_at_min_1", at_min, 1);
      chk("s5_upd_cnt", upd_cnt, 1);

      // Reset mid-debounce aborts; button held through release is a fresh press
      do_reset();
      clr();
      btn_inc = 1'b1;
      cyc(10);
      rst_n = 1'b0;
      cyc(5);
      chk("s6_rst_duty", duty, 5);
      chk("s6_rst_upd_cnt", upd_cnt, 0);
      rst_n = 1'b1;
      clr();
      cyc(19);
      chk("s6_duty_e19", duty, 5);
      cyc(1);
      chk("s6_duty_e20", duty, 6);
      chk("s6_upd_cnt", upd_cnt, 1);
      btn_inc = 1'b0;
      cyc(5);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/pwm_duty_ctrl.md
PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 Parameter DUTY_W, default 4: width of duty output.
REQ-002 Parameter DUTY_MAX, default 10: largest legal duty; equals the PWM period in clk cycles.
REQ-003 Parameter DUTY_INIT, default 5: duty value after reset.
REQ-004 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronised samples required to accept a level change.
REQ-005 Parameter HOLD_CYCLES, default 64: cycles a button must stay pressed after its first step before auto-repeat starts.
REQ-006 Parameter REPEAT_CYCLES, default 16: auto-repeat step interval in clk cycles.
REQ-007 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-008 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-009 Port btn_inc, input, 1: raw, asynchronous, bouncing increase button, active-high.
REQ-010 Port btn_dec, input, 1: raw, asynchronous, bouncing decrease button, active-high.
REQ-011 Port duty, output, DUTY_W: registered duty value for the downstream PWM stage, range 0..DUTY_MAX.
REQ-012 Port duty_upd, output, 1: one-cycle strobe in the cycle after duty changes.
REQ-013 Port at_max, output, 1: high while duty == DUTY_MAX.
REQ-014 Port at_min, output, 1: high while duty == 0.

Function
REQ-015 Each button SHALL pass through a 2-flop synchroniser before any other logic.
REQ-016 Each synchronised button SHALL feed its own debouncer FSM with states IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
REQ-017 IDLE -> CONFIRM_PRESS on a synced high; CONFIRM_PRESS -> PRESSED after DEBOUNCE_CYCLES consecutive highs; any low in CONFIRM_PRESS returns to IDLE and clears the counter.
REQ-018 PRESSED -> CONFIRM_RELEASE on a synced low; CONFIRM_RELEASE -> IDLE after DEBOUNCE_CYCLES consecutive lows; any high in CONFIRM_RELEASE returns to PRESSED.
REQ-019 The debouncer SHALL emit a one-cycle step pulse on entry to PRESSED.
REQ-020 While in PRESSED, the debouncer SHALL emit another step pulse HOLD_CYCLES cycles after the entry pulse, then one every REPEAT_CYCLES cycles, until it leaves PRESSED.
REQ-021 Latency: with a clean press, the first step pulse SHALL be high on edge DEBOUNCE_CYCLES+3 after the first clk edge that samples btn high; duty SHALL change on the next edge.
REQ-022 An inc step SHALL update duty to duty+1, saturating at DUTY_MAX.
REQ-023 A dec step SHALL update duty to duty-1, saturating at 0; duty SHALL never wrap.
REQ-024 An inc step and a dec step in the same cycle SHALL leave duty unchanged and produce no duty_upd.
REQ-025 A step that is blocked by saturation SHALL leave duty unchanged and produce no duty_upd.
REQ-026 duty_upd SHALL pulse for exactly one cycle per actual duty change.
REQ-027 at_max and at_min SHALL be registered and change in the same cycle as duty.
REQ-028 duty SHALL change only on clk edges; a downstream PWM stage SHALL be able to consume it directly in the clk domain.

Reset
REQ-029 While rst_n is low: duty = DUTY_INIT, duty_upd = 0, at_max = (DUTY_INIT == DUTY_MAX), at_min = (DUTY_INIT == 0).
REQ-030 While rst_n is low: both FSMs are in IDLE, and all counters and synchroniser flops are 0.
REQ-031 A button held through reset deassertion SHALL be treated as a fresh press, with the full debounce delay.
REQ-032 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no step pulse emitted.

Structure
REQ-033 A shared package SHALL hold the debouncer state enum and the DUTY_W/DUTY_MAX/DUTY_INIT defaults, shared with the PWM stage.
REQ-034 The debouncer (synchroniser, FSM and repeat timer) SHALL be one sub-module, btn_debounce, instantiated twice.
REQ-035 Counter widths SHALL be derived with $clog2 of the largest count.

Verification (defaults)
REQ-036 Scenario 1: hold btn_inc clean for 40 cycles -> exactly one duty_upd; duty 5->6 on edge 20.
REQ-037 Scenario 2: btn_inc toggles every 3 cycles for 30 cycles, then held low -> duty stays 5 and no duty_upd.
REQ-038 Scenario 3: hold btn_inc for 200 cycles -> steps at edges 19, 83, 99, 115, 131, ...; duty saturates at 10, at_max=1, no further duty_upd.
REQ-039 Scenario 4: both buttons pressed in the same cycle and held 30 cycles -> duty stays 5 and no duty_upd.
REQ-040 Scenario 5: starting from duty 1, press btn_dec twice -> duty 0, at_min=1, exactly one duty_upd.
REQ-041 Scenario 6: rst_n pulled low 10 cycles into a btn_inc press -> duty 5 and no pulse; release rst_n with the button held -> step 20 edges later.
